// File: rtl/mips_pkg.sv
// mips_pkg: shared decode constants for the single-cycle MIPS core.
//   - opcode and funct field encodings of the supported instruction subset
//   - ALU operation enum selected by the decoder
//   - immediate sign-extension helper
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit register file.
//   clk        : write clock (rising edge)
//   rst_n      : asynchronous active-low clear of all registers
//   ra1/ra2    : combinational read addresses, rd1/rd2 the read data
//   we/wa/wd   : synchronous write port; writes to register 0 are dropped
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs_q [0:31];

  // Register storage: cleared on reset, one write per cycle, entry 0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Read ports: register 0 is forced to zero independent of storage.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];
  end

endmodule

// File: rtl/mips_word_ram.sv
// mips_word_ram: word-addressed RAM used for both instruction and data memory.
//   clk       : write clock (rising edge)
//   we        : write enable
//   word_addr : byte address with the two low bits already dropped
//   wdata     : write data, rdata : combinational read data
// Word indices beyond the depth wrap modulo WORDS. Contents are not reset.
module mips_word_ram #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] RAM [0:WORDS-1];
  logic [29:0] word_mod;
  logic [AW-1:0] idx;

  // Address wrap into the implemented depth.
  always_comb begin
    word_mod = word_addr % 30'(WORDS);
    idx      = word_mod[AW-1:0];
    rdata    = RAM[idx];
  end

  // Synchronous word write.
  always_ff @(posedge clk) begin
    if (we) begin
      RAM[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mips_single_cycle_core.sv
// mips_single_cycle_core: single-cycle 32-bit MIPS subset (one instruction per clk).
//   clk   : single clock, all state updates on the rising edge
//   reset : asynchronous active-low; clears pc to RESET_PC and the register file
// No functional outputs; state is observed through pc, imem.RAM and dmem.RAM.
module mips_single_cycle_core #(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset
);
  import mips_pkg::*;

  logic [31:0] pc, pc_d, pc_plus4, instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [15:0] imm;
  logic [25:0] target;

  alu_op_e     alu_op;
  logic        alu_src_imm, imm_zext, reg_we, dst_rd, mem_we, mem_to_reg;
  logic        is_beq, is_bne, is_j, br_taken;
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, dmem_rdata, wb_data;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  mips_word_ram #(.WORDS(IMEM_WORDS)) imem (
    .clk       (clk),
    .we        (1'b0),
    .word_addr (pc[31:2]),
    .wdata     (32'd0),
    .rdata     (instr)
  );

  mips_regfile rf (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rs_val),
    .rd2   (rt_val),
    .we    (reg_we),
    .wa    (wa),
    .wd    (wb_data)
  );

  mips_word_ram #(.WORDS(DMEM_WORDS)) dmem (
    .clk       (clk),
    .we        (mem_we),
    .word_addr (alu_res[31:2]),
    .wdata     (rt_val),
    .rdata     (dmem_rdata)
  );

  // Control decode; unsupported op/funct leave every write disabled (NOP).
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    imm_zext    = 1'b0;
    reg_we      = 1'b0;
    dst_rd      = 1'b0;
    mem_we      = 1'b0;
    mem_to_reg  = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_j        = 1'b0;
    case (op)
      OP_RTYPE: begin
        dst_rd = 1'b1;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_ANDI: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_AND;
      end
      OP_ORI: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        imm_zext    = 1'b1;
        alu_op      = ALU_OR;
      end
      OP_LW: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        alu_src_imm = 1'b1;
        mem_we      = 1'b1;
      end
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j   = 1'b1;
      default: reg_we = 1'b0;
    endcase
  end

  // ALU and write-back selection; sll shifts rt, not the rs operand.
  always_comb begin
    imm_ext = imm_zext ? {16'h0000, imm} : sext16(imm);
    alu_b   = alu_src_imm ? imm_ext : rt_val;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_SLL: alu_res = rt_val << shamt;
      default: alu_res = 32'd0;
    endcase
    wb_data = mem_to_reg ? dmem_rdata : alu_res;
    wa      = dst_rd ? rd : rt;
  end

  // Next-PC selection: jump, taken branch, or sequential.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_taken = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
    if (is_j) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if (br_taken) begin
      pc_d = pc_plus4 + (sext16(imm) << 2);
    end else begin
      pc_d = pc_plus4;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_d;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle_core.sv
module tb_mips_single_cycle_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_single_cycle_core #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (64),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  int errors = 0;
  int checks = 0;

  // Reference machine state (architectural level).
  logic [31:0] prog     [64];
  logic [31:0] ref_rf   [32];
  logic [31:0] ref_dmem [64];
  logic [31:0] ref_pc;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic logic [4:0] r5();
    return 5'($urandom_range(0, 15));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    ref_pc = 32'h0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
  endtask

  task automatic ref_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) ref_rf[r] = v;
  endtask

  // Execute one instruction on the reference machine.
  task automatic ref_step();
    logic [31:0] ins, a, b, simm, zimm, nxt, addr;
    ins  = prog[ref_pc[7:2]];
    a    = ref_rf[ins[25:21]];
    b    = ref_rf[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'h0000, ins[15:0]};
    addr = a + simm;
    nxt  = ref_pc + 32'd4;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20:   ref_wr(ins[15:11], a + b);
          6'h22:   ref_wr(ins[15:11], a - b);
          6'h24:   ref_wr(ins[15:11], a & b);
          6'h25:   ref_wr(ins[15:11], a | b);
          6'h2A:   ref_wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h00:   ref_wr(ins[15:11], b << ins[10:6]);
          default: ;
        endcase
      end
      6'h08:   ref_wr(ins[20:16], a + simm);
      6'h0C:   ref_wr(ins[20:16], a & zimm);
      6'h0D:   ref_wr(ins[20:16], a | zimm);
      6'h23:   ref_wr(ins[20:16], ref_dmem[addr[7:2]]);
      6'h2B:   ref_dmem[addr[7:2]] = b;
      6'h04:   if (a == b) nxt = nxt + (simm << 2);
      6'h05:   if (a != b) nxt = nxt + (simm << 2);
      6'h02:   nxt = {nxt[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    ref_pc = nxt;
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      ref_step();
      @(negedge clk);
      check($sformatf("%s_pc%0d", tag, i), dut.pc, ref_pc);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", tag, i), dut.rf.regs_q[i], ref_rf[i]);
  endtask

  // Hold reset 3 cycles, load prog while held, release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    for (int i = 0; i < 64; i++) dut.imem.RAM[i] = prog[i];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("%s_rst_pc%0d", tag, i), dut.pc, 32'h0);
    end
    reset = 1'b1;
    #1;
    check($sformatf("%s_first_fetch", tag), dut.instr, prog[0]);
    check_regs($sformatf("%s_rst", tag));
  endtask

  task automatic gen_random();
    int idx, kind, off;
    logic [5:0] fn, op;
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    for (int k = 1; k <= 8; k++) begin
      prog[k-1] = enc_i(6'h08, 5'd0, 5'(k), 16'($urandom_range(0, 65535)));
      prog[7+k] = enc_i(6'h2B, 5'd0, 5'(k), 16'(32'h80 + 4 * (k - 1)));
    end
    idx = 16;
    while (idx < 56) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: begin
          case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'h00;
          endcase
          prog[idx] = enc_r(fn, r5(), r5(), r5(), 5'($urandom_range(0, 31)));
        end
        2: begin
          case ($urandom_range(0, 2))
            0: op = 6'h08;
            1: op = 6'h0C;
            default: op = 6'h0D;
          endcase
          prog[idx] = enc_i(op, r5(), r5(), 16'($urandom));
        end
        3, 4: begin
          // Offsets +0x100 wrap back onto the same 8-word window.
          op = (kind == 3) ? 6'h23 : 6'h2B;
          prog[idx] = enc_i(op, 5'd0, r5(),
                            16'(32'h80 + 4 * $urandom_range(0, 7) +
                                (($urandom_range(0, 1) != 0) ? 32'h100 : 32'h0)));
        end
        5: begin
          off = 55 - idx;
          if (off > 2) off = 2;
          op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05;
          prog[idx] = enc_i(op, 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                            16'($urandom_range(0, off)));
        end
        6: begin
          if ($urandom_range(0, 1) != 0) prog[idx] = enc_i(6'h3F, r5(), r5(), 16'($urandom));
          else prog[idx] = enc_r(6'h3F, r5(), r5(), r5(), 5'd0);
        end
        default: prog[idx] = enc_i(6'h08, r5(), r5(), 16'($urandom));
      endcase
      idx++;
    end
    prog[56] = enc_j(26'd56);
  endtask

  initial begin
    logic [31:0] fib_exp [15];
    logic [31:0] alu_exp [5];
    fib_exp = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h3, 32'h5, 32'h8, 32'hd,
                32'h15, 32'h22, 32'h37, 32'h59, 32'h90, 32'he9, 32'h179};
    alu_exp = '{32'h2, 32'h8, 32'h5, 32'hFFFF_FFFD, 32'h1};

    // ---------------- ALU / memory / branch program ----------------
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    prog[3]  = enc_r(6'h22, 5'd1, 5'd2, 5'd4, 5'd0);
    prog[4]  = enc_r(6'h24, 5'd1, 5'd2, 5'd5, 5'd0);
    prog[5]  = enc_r(6'h25, 5'd1, 5'd2, 5'd6, 5'd0);
    prog[6]  = enc_r(6'h2A, 5'd2, 5'd1, 5'd7, 5'd0);
    for (int k = 0; k < 5; k++) prog[7+k] = enc_i(6'h2B, 5'd0, 5'(3 + k), 16'(4 * k));
    prog[12] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
    prog[13] = enc_i(6'h23, 5'd0, 5'd8, 16'h0040);
    prog[14] = enc_r(6'h00, 5'd0, 5'd1, 5'd9, 5'd4);
    prog[15] = enc_i(6'h0C, 5'd2, 5'd10, 16'hFF00);
    prog[16] = enc_i(6'h0D, 5'd0, 5'd11, 16'h8001);
    prog[17] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    prog[18] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    prog[19] = enc_i(6'h08, 5'd0, 5'd12, 16'd1);
    prog[20] = enc_i(6'h08, 5'd0, 5'd12, 16'd2);
    prog[21] = enc_i(6'h05, 5'd1, 5'd1, 16'd3);
    prog[22] = enc_r(6'h3F, 5'd1, 5'd1, 5'd14, 5'd0);
    prog[23] = enc_i(6'h3F, 5'd1, 5'd14, 16'd1);
    prog[24] = enc_i(6'h08, 5'd0, 5'd13, 16'd9);
    prog[25] = enc_j(26'h11);

    do_reset("alu");
    run_cycles(19, "alu");
    check("beq_taken_pc", dut.pc, 32'h54);
    run_cycles(1, "bne");
    check("bne_fallthrough_pc", dut.pc, 32'h58);
    run_cycles(4, "tail");
    check("j_target_pc", dut.pc, 32'h44);
    for (int k = 0; k < 5; k++) check($sformatf("alu_dmem%0d", k), dut.dmem.RAM[k], alu_exp[k]);
    check("sw_dmem16", dut.dmem.RAM[16], 32'h5);
    check("lw_r8", dut.rf.regs_q[8], 32'h5);
    check("slt_r7", dut.rf.regs_q[7], 32'h1);
    check("sll_r9", dut.rf.regs_q[9], 32'h50);
    check("andi_r10", dut.rf.regs_q[10], 32'h0000_FF00);
    check("ori_r11", dut.rf.regs_q[11], 32'h0000_8001);
    check("r0_zero", dut.rf.regs_q[0], 32'h0);
    check("beq_skip_r12", dut.rf.regs_q[12], 32'h0);
    check("after_bne_r13", dut.rf.regs_q[13], 32'h9);
    check("nop_r14", dut.rf.regs_q[14], 32'h0);
    check_regs("alu_end");

    // ---------------- Fibonacci with mid-run reset ----------------
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd0);
    prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    prog[2]  = enc_i(6'h08, 5'd0, 5'd3, 16'h0040);
    prog[3]  = enc_i(6'h08, 5'd0, 5'd4, 16'd15);
    prog[4]  = enc_i(6'h2B, 5'd3, 5'd1, 16'd0);
    prog[5]  = enc_r(6'h20, 5'd1, 5'd2, 5'd5, 5'd0);
    prog[6]  = enc_i(6'h08, 5'd2, 5'd1, 16'd0);
    prog[7]  = enc_i(6'h08, 5'd5, 5'd2, 16'd0);
    prog[8]  = enc_i(6'h08, 5'd3, 5'd3, 16'd4);
    prog[9]  = enc_i(6'h08, 5'd4, 5'd4, 16'hFFFF);
    prog[10] = enc_i(6'h05, 5'd4, 5'd0, 16'hFFF9);
    prog[11] = enc_j(26'h11);
    prog[17] = enc_j(26'h11);

    do_reset("fib0");
    run_cycles(60, "fib0");
    ref_step();
    @(posedge clk);
    #2 reset = 1'b0;
    ref_reset();
    #1;
    check("midrst_pc", dut.pc, 32'h0);
    check_regs("midrst");
    for (int k = 0; k < 31; k++) check($sformatf("midrst_dmem%0d", k), dut.dmem.RAM[k], ref_dmem[k]);
    for (int k = 0; k < 5; k++) check($sformatf("midrst_alu_dmem%0d", k), dut.dmem.RAM[k], alu_exp[k]);
    @(negedge clk);
    check("midrst_hold_pc", dut.pc, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    run_cycles(120, "fib");
    check("fib_end_pc", dut.pc, 32'h44);
    for (int k = 0; k < 15; k++) check($sformatf("fib_dmem%0d", 16 + k), dut.dmem.RAM[16+k], fib_exp[k]);
    check_regs("fib_end");

    // ---------------- Randomized programs ----------------
    for (int t = 0; t < 3; t++) begin
      gen_random();
      do_reset($sformatf("rnd%0d", t));
      run_cycles(64, $sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_end_pc", t), dut.pc, 32'hE0);
      check_regs($sformatf("rnd%0d_end", t));
      for (int k = 32; k < 40; k++)
        check($sformatf("rnd%0d_dmem%0d", t, k), dut.dmem.RAM[k], ref_dmem[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
